// File: rtl/uart_dac_pkg.sv
// Shared types and helpers for the UART-driven DAC receiver.
// Checksum byte support is selected with UART_DAC_CHKSUM_EN.
package uart_dac_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        PS_HUNT,
        PS_HI,
        PS_LO,
        PS_CHK
    } ps_state_e;

    function automatic int unsigned bit_cyc(
        input int unsigned clk_fre,
        input int unsigned rate
    );
        return (clk_fre * 1_000_000) / rate;
    endfunction

endpackage

// File: rtl/uart_dac_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit sampling FSM,
// registered byte strobe and stop-bit error strobe.
module uart_byte_rx
    import uart_dac_pkg::*;
#(
    parameter int unsigned BIT_CYC = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_err_o
);

    localparam int unsigned CNT_W = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

    logic             meta_q;
    logic             sync_q;
    logic             prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // line back high at mid start bit: treat as noise
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = sync_q;
                    err_d   = !sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign byte_err_o   = err_q;

endmodule

// File: rtl/uart_dac_rx.sv
// UART command receiver driving a 10-bit DAC code from A5-headed frames.
// UART_DAC_CHKSUM_EN adds a trailing XOR checksum byte to each frame.
module uart_dac_rx
    import uart_dac_pkg::*;
#(
    parameter int unsigned CLK_FRE       = 50,
    parameter int unsigned UART_RATE     = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [9:0] dac_data,
    output logic       dac_update,
    output logic       frame_err
);

    localparam int unsigned BIT_CYC = bit_cyc(CLK_FRE, UART_RATE);
    localparam int unsigned TO_CYC  = TIMEOUT_BYTES * 10 * BIT_CYC;
    localparam int unsigned TO_W    = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;

    ps_state_e       ps_q, ps_d;
    logic [1:0]      hi_q, hi_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [9:0]      dac_q, dac_d;
    logic            upd_q, upd_d;
    logic            err_q, err_d;
`ifdef UART_DAC_CHKSUM_EN
    logic [7:0]      lo_q, lo_d;
    logic            chk_ok;
`endif

    uart_byte_rx #(
        .BIT_CYC (BIT_CYC)
    ) u_byte_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (uart_rx),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .byte_err_o   (byte_err)
    );

`ifdef UART_DAC_CHKSUM_EN
    assign chk_ok = (byte_data == ({6'd0, hi_q} ^ lo_q));
`endif

    always_comb begin
        ps_d  = ps_q;
        hi_d  = hi_q;
        dac_d = dac_q;
        upd_d = 1'b0;
        err_d = 1'b0;
`ifdef UART_DAC_CHKSUM_EN
        lo_d  = lo_q;
`endif
        // idle time is measured from the most recent byte of the frame
        if (ps_q == PS_HUNT || byte_valid) begin
            to_d = '0;
        end else begin
            to_d = to_q + TO_W'(1);
        end

        if (byte_err) begin
            err_d = 1'b1;
            ps_d  = PS_HUNT;
        end else if (byte_valid) begin
            unique case (ps_q)
                PS_HUNT: begin
                    if (byte_data == FRAME_HDR) begin
                        ps_d = PS_HI;
                    end
                end
                PS_HI: begin
                    if (|byte_data[7:2]) begin
                        err_d = 1'b1;
                        ps_d  = PS_HUNT;
                    end else begin
                        hi_d = byte_data[1:0];
                        ps_d = PS_LO;
                    end
                end
                PS_LO: begin
`ifdef UART_DAC_CHKSUM_EN
                    lo_d = byte_data;
                    ps_d = PS_CHK;
`else
                    dac_d = {hi_q, byte_data};
                    upd_d = 1'b1;
                    ps_d  = PS_HUNT;
`endif
                end
`ifdef UART_DAC_CHKSUM_EN
                PS_CHK: begin
                    if (chk_ok) begin
                        dac_d = {hi_q, lo_q};
                        upd_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    ps_d = PS_HUNT;
                end
`endif
                default: ps_d = PS_HUNT;
            endcase
        end else if (ps_q != PS_HUNT && to_q == TO_LAST) begin
            err_d = 1'b1;
            ps_d  = PS_HUNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q  <= PS_HUNT;
            hi_q  <= '0;
            to_q  <= '0;
            dac_q <= '0;
            upd_q <= 1'b0;
            err_q <= 1'b0;
`ifdef UART_DAC_CHKSUM_EN
            lo_q  <= '0;
`endif
        end else begin
            ps_q  <= ps_d;
            hi_q  <= hi_d;
            to_q  <= to_d;
            dac_q <= dac_d;
            upd_q <= upd_d;
            err_q <= err_d;
`ifdef UART_DAC_CHKSUM_EN
            lo_q  <= lo_d;
`endif
        end
    end

    assign dac_data   = dac_q;
    assign dac_update = upd_q;
    assign frame_err  = err_q;

endmodule
